// File: rtl/dbus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream data-bus port among N_REQ requesters.
// The granted request is latched and held on the bus until downstream data_ok.

package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_rr_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  dbus_req_t  [N_REQ-1:0] ireq_i,
  output dbus_resp_t [N_REQ-1:0] iresp_o,
  output dbus_req_t              oreq_o,
  input  dbus_resp_t             oresp_i
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  dbus_req_t        saved_q, saved_d;

  logic [IDX_W-1:0] sel;
  logic             any;
  logic             gnt_act;
  logic [IDX_W-1:0] gnt_idx;

  // Wrap at N_REQ, not at 2^IDX_W.
  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (32'(i) == N_REQ - 1) begin
      return '0;
    end
    return i + IDX_W'(1);
  endfunction

  always_comb begin
    int unsigned idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any && ireq_i[idx[IDX_W-1:0]].valid) begin
        any = 1'b1;
        sel = idx[IDX_W-1:0];
      end
    end
    // Requests are invisible while reset is held so nothing reaches the bus.
    any = any & rst_ni;
  end

  always_comb begin
    gnt_act = any;
    gnt_idx = sel;
    if (state_q == StBusy) begin
      gnt_act = rst_ni;
      gnt_idx = gidx_q;
    end
  end

  always_comb begin
    oreq_o = '0;
    if (rst_ni) begin
      if (state_q == StBusy) begin
        oreq_o = saved_q;
      end else if (any) begin
        oreq_o = ireq_i[sel];
      end
    end
  end

  always_comb begin
    iresp_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      iresp_o[k].data    = oresp_i.data;
      iresp_o[k].data_ok = gnt_act && (gnt_idx == IDX_W'(k)) && oresp_i.data_ok;
      iresp_o[k].addr_ok = iresp_o[k].data_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    saved_d = saved_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          if (oresp_i.data_ok) begin
            ptr_d = inc_idx(sel);
          end else begin
            saved_d = ireq_i[sel];
            gidx_d  = sel;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (oresp_i.data_ok) begin
          ptr_d   = inc_idx(gidx_q);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gidx_q  <= '0;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      saved_q <= saved_d;
    end
  end

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// Bench for dbus_rr_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; a second 3-requester instance covers wrap-around.

module tb_dbus_rr_arbiter;
  import dbus_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;

  dbus_req_t  [N-1:0] ireq;
  dbus_resp_t [N-1:0] iresp;
  dbus_req_t          oreq;
  dbus_resp_t         oresp;

  dbus_req_t  [2:0]   ireq3;
  dbus_resp_t [2:0]   iresp3;
  dbus_req_t          oreq3;
  dbus_resp_t         oresp3;

  int checks   = 0;
  int failures = 0;

  // Reference model: the pending transaction and the priority pointer.
  int        m_ptr   = 0;
  bit        m_busy  = 1'b0;
  int        m_gidx  = 0;
  dbus_req_t m_saved = '0;
  int        exp_g   = -1;

  always #5 clk = ~clk;

  dbus_rr_arbiter #(.N_REQ(N)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ireq_i  (ireq),
    .iresp_o (iresp),
    .oreq_o  (oreq),
    .oresp_i (oresp)
  );

  dbus_rr_arbiter #(.N_REQ(3)) u_dut3 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .ireq_i  (ireq3),
    .iresp_o (iresp3),
    .oreq_o  (oreq3),
    .oresp_i (oresp3)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] dok4();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = iresp[k].data_ok;
    return r;
  endfunction

  function automatic logic [2:0] dok3();
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = iresp3[k].data_ok;
    return r;
  endfunction

  function automatic logic [31:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  task automatic set_reqs(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      ireq[k].valid  = mask[k];
      ireq[k].addr   = addr_of(k);
      ireq[k].size   = 3'd2;
      ireq[k].strobe = 4'hf;
      ireq[k].data   = 32'hA000_0000 + 32'(k);
    end
  endtask

  // Mid-cycle: predict the outputs from the model and compare the whole bus.
  task automatic at_neg();
    dbus_req_t          exp_oreq;
    dbus_resp_t [N-1:0] exp_resp;
    @(negedge clk);
    exp_g    = -1;
    exp_oreq = '0;
    if (rst_n === 1'b1) begin
      if (m_busy) begin
        exp_g    = m_gidx;
        exp_oreq = m_saved;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (exp_g < 0 && ireq[j].valid) exp_g = j;
        end
        if (exp_g >= 0) exp_oreq = ireq[exp_g];
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_resp[k].data    = oresp.data;
      exp_resp[k].data_ok = (exp_g == k) && oresp.data_ok;
      exp_resp[k].addr_ok = exp_resp[k].data_ok;
    end
    chk("oreq", 256'(oreq), 256'(exp_oreq));
    chk("iresp", 256'(iresp), 256'(exp_resp));
  endtask

  task automatic to_pos();
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_ptr   = 0;
      m_busy  = 1'b0;
      m_gidx  = 0;
      m_saved = '0;
    end else if (m_busy) begin
      if (oresp.data_ok) begin
        m_busy = 1'b0;
        m_ptr  = (m_gidx + 1) % N;
      end
    end else if (exp_g >= 0) begin
      if (oresp.data_ok) begin
        m_ptr = (exp_g + 1) % N;
      end else begin
        m_busy  = 1'b1;
        m_gidx  = exp_g;
        m_saved = ireq[exp_g];
      end
    end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    to_pos();
  endtask

  initial begin
    rst_n  = 1'b0;
    ireq3  = '0;
    oresp3 = '0;
    oresp  = '0;
    oresp.data    = 32'h55;
    oresp.data_ok = 1'b1;
    set_reqs(4'hf);
    #1;

    // Reset held with every requester valid and data_ok high.
    repeat (2) begin
      at_neg();
      chk("rst_oreq_valid", 256'(oreq.valid), 256'(1'b0));
      chk("rst_dok", 256'(dok4()), 256'(4'b0000));
      to_pos();
    end
    rst_n = 1'b1;
    oresp.data_ok = 1'b0;

    // Round robin, data_ok two cycles after each grant; grant 0 is the release cycle.
    for (int t = 0; t < 5; t++) begin
      at_neg();
      chk("rr_valid", 256'(oreq.valid), 256'(1'b1));
      chk("rr_grant", 256'(oreq.addr), 256'(addr_of(t % N)));
      to_pos();
      cyc();
      oresp.data_ok = 1'b1;
      at_neg();
      chk("rr_dok", 256'(dok4()), 256'(4'b0001 << (t % N)));
      to_pos();
      oresp.data_ok = 1'b0;
    end

    // Latched request survives payload change, dropped valid and a new arrival.
    set_reqs(4'b0100);
    ireq[2].addr = 32'h8000_1000;
    at_neg();
    chk("latch_grant", 256'(oreq.addr), 256'(32'h8000_1000));
    to_pos();
    ireq[2].addr  = 32'h0000_DEAD;
    ireq[2].valid = 1'b0;
    ireq[0].valid = 1'b1;
    repeat (2) begin
      at_neg();
      chk("latch_addr", 256'(oreq.addr), 256'(32'h8000_1000));
      chk("latch_nodok", 256'(dok4()), 256'(4'b0000));
      to_pos();
    end
    oresp.data_ok = 1'b1;
    at_neg();
    chk("latch_addr_done", 256'(oreq.addr), 256'(32'h8000_1000));
    chk("latch_dok", 256'(dok4()), 256'(4'b0100));
    to_pos();
    oresp.data_ok = 1'b0;
    set_reqs(4'b0000);
    cyc();

    // Zero-wait completions from a fresh reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    oresp.data_ok = 1'b1;
    set_reqs(4'b1010);
    at_neg();
    chk("zw_first", 256'(dok4()), 256'(4'b0010));
    to_pos();
    set_reqs(4'b1000);
    at_neg();
    chk("zw_second", 256'(dok4()), 256'(4'b1000));
    to_pos();
    set_reqs(4'hf);
    at_neg();
    chk("zw_ptr_wrap", 256'(dok4()), 256'(4'b0001));
    to_pos();
    oresp.data_ok = 1'b0;
    set_reqs(4'b0000);
    cyc();

    // Reset during a wait drops the transaction silently.
    set_reqs(4'b0010);
    at_neg();
    chk("mid_grant", 256'(oreq.addr), 256'(addr_of(1)));
    to_pos();
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(oreq.valid), 256'(1'b0));
    oresp.data_ok = 1'b1;
    at_neg();
    chk("mid_rst_dok", 256'(dok4()), 256'(4'b0000));
    to_pos();
    rst_n = 1'b1;
    oresp.data_ok = 1'b0;
    set_reqs(4'hf);
    at_neg();
    chk("mid_restart", 256'(oreq.addr), 256'(addr_of(0)));
    to_pos();
    oresp.data_ok = 1'b1;
    cyc();
    oresp.data_ok = 1'b0;
    set_reqs(4'b0000);
    cyc();

    // Three requesters: pointer 2 must wrap to 0.
    ireq3[1].valid = 1'b1;
    oresp3.data_ok = 1'b1;
    at_neg();
    chk("w3_first", 256'(dok3()), 256'(3'b010));
    to_pos();
    ireq3[1].valid = 1'b0;
    ireq3[0].valid = 1'b1;
    ireq3[2].valid = 1'b1;
    at_neg();
    chk("w3_idx2", 256'(dok3()), 256'(3'b100));
    to_pos();
    ireq3[2].valid = 1'b0;
    at_neg();
    chk("w3_wrap0", 256'(dok3()), 256'(3'b001));
    to_pos();
    ireq3 = '0;
    oresp3.data_ok = 1'b0;

    // Random traffic, including contract violations and sporadic reset.
    repeat (400) begin
      for (int k = 0; k < N; k++) begin
        ireq[k].valid  = 1'($urandom_range(0, 1));
        ireq[k].addr   = $urandom;
        ireq[k].size   = 3'($urandom_range(0, 7));
        ireq[k].strobe = 4'($urandom_range(0, 15));
        ireq[k].data   = $urandom;
      end
      oresp.data_ok = ($urandom_range(0, 2) == 0);
      oresp.data    = $urandom;
      rst_n         = ($urandom_range(0, 63) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_rr_arbiter.md
# dbus_rr_arbiter

Round-robin arbiter that shares one downstream data-bus port among `N_REQ` requesters, such as the per-port outputs of a memory-stage arbiter, an I-cache refill and a D-cache writeback. A transaction holds the bus until the downstream `data_ok`. While held, the request is latched so the downstream sees a stable request even if the requester drops or changes it. The block sits between the cache/memory-stage requesters and the single `dbus` port toward the memory interface.

## Interface
- `N_REQ`, default 4: number of requesters; legal values are 2..16.
- `IDX_W`, default `$clog2(N_REQ)`: width of the grant index and priority pointer.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ireq`  in  `dbus_req_t [N_REQ-1:0]`  requester requests (`valid`, `addr`, `size`, `strobe`, `data`).
- `iresp`  out  `dbus_resp_t [N_REQ-1:0]`  per-requester responses.
- `oreq`  out  `dbus_req_t`  request to the downstream port.
- `oresp`  in  `dbus_resp_t`  downstream response.

## Operation
- **State:**
  - `state` ∈ {IDLE, BUSY}.
  - `ptr` (`IDX_W` bits): index of the highest-priority requester.
  - `gidx` (`IDX_W` bits): index of the granted requester.
  - `saved` (`dbus_req_t`): latched copy of the granted request.
- **Selection (combinational, IDLE only):**
  - Scan indices `ptr`, `ptr+1`, …, wrapping modulo `N_REQ` (not modulo `2^IDX_W`).
  - The first index `i` with `ireq[i].valid` is the selection `sel`.
  - `any` = OR of all `ireq[*].valid`.
- **IDLE:**
  - `oreq` = `ireq[sel]` if `any`, else `'0`.
  - If `any` and `oresp.data_ok` in the same cycle: zero-wait completion. Stay in IDLE; `ptr` ← (`sel`+1) mod `N_REQ`.
  - If `any` and no `data_ok`: `saved` ← `ireq[sel]`, `gidx` ← `sel`, go to BUSY. `ptr` is unchanged.
- **BUSY:**
  - `oreq` = `saved`, regardless of the current `ireq` values.
  - On `oresp.data_ok`: go to IDLE; `ptr` ← (`gidx`+1) mod `N_REQ`.
  - Without `data_ok`: hold all state.
- **Responses:**
  - `iresp[k].data_ok` = `oresp.data_ok` when k is the current grant (`sel` in IDLE with `any`, `gidx` in BUSY); otherwise 0.
  - `iresp[k].addr_ok` = `iresp[k].data_ok`.
  - `iresp[k].data` = `oresp.data` for every k; only the granted requester may consume it.
- **Requester contract:**
  - A requester keeps `valid` and its payload stable until it sees its own `data_ok`.
  - If a requester drops `valid` while BUSY, the latched transaction still completes downstream and its `data_ok` still pulses; the requester ignores it. No abort exists.
- **Downstream contract:**
  - `oresp.data_ok` is only meaningful while `oreq.valid` = 1.
  - In IDLE with `any` = 0 (so `oreq.valid` = 0), a `data_ok` has no effect and no `iresp` pulses.

## Timing
- **Reset** (`reset` = 0, asynchronous):
  - Clears to `state` = IDLE, `ptr` = 0, `gidx` = 0, `saved` = `'0`.
  - `oreq.valid` falls immediately (combinationally) while `reset` is low.
  - All `iresp[*].data_ok` = 0 while `reset` is low.
- **Reset mid-BUSY:** the transaction is dropped with no response. Downstream is reset in the same domain.
- **Grant latency:** zero cycles. The request appears on `oreq` in the same cycle it is raised in IDLE.
- **Completion:** at most one transaction completes per cycle. The cycle after a completion is IDLE, so the next grant issues with no bubble.
- **Fairness:** a continuously-requesting requester waits at most `N_REQ`-1 transactions.
- **Wrap-around:** when `gidx` = `N_REQ`-1, `ptr` becomes 0, also for non-power-of-two `N_REQ`.
- **Simultaneous events:** a new `ireq` arriving in BUSY never changes `oreq` or `gidx`; it waits for IDLE.

## Test plan
- **Reset values:** hold `reset` = 0 while all four requesters assert `valid` → `oreq.valid` = 0 and every `iresp.data_ok` = 0. Release reset → requester 0 granted that cycle (`ptr` = 0).
- **Round-robin order:** requesters 0–3 all valid; downstream returns `data_ok` 2 cycles after each `oreq`. The grant order is 0, 1, 2, 3, 0, with each `data_ok` routed only to the granted index. Back-to-back grants show no idle cycle.
- **Latch stability:** requester 2 is granted with `addr` 0x80001000, then changes `addr` to 0xDEAD and drops `valid` after 1 cycle. `oreq.addr` stays 0x80001000 until `data_ok`, and `iresp[2].data_ok` still pulses once.
- **Zero-wait completion:** `oresp.data_ok` tied high with requesters 1 and 3 valid → requester 1 completes in the first cycle and requester 3 in the next. `ptr` ends at 0.
- **Wrap with `N_REQ` = 3:** grants go 2 then 0, and index 3 is never selected.
- **Reset mid-BUSY:** assert `reset` low during a 5-cycle wait → `oreq.valid` drops immediately with no `iresp` pulse. After release, arbitration restarts from requester 0.
